// File: rtl/motor_ramp_pkg.sv
// Shared types and constants for the motor ramp limiter / command watchdog.
package motor_ramp_pkg;

  localparam int unsigned RATIO_W   = 8;
  localparam int unsigned CMD_W     = 16;
  localparam int unsigned RIGHT_LSB = 0;
  localparam int unsigned LEFT_LSB  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_TRIP = 2'd2
  } state_e;

endpackage

// File: rtl/motor_ramp_if.sv
// Command / ratio bundle between the SoC PWM register and the ramp limiter.
interface motor_ramp_if
  import motor_ramp_pkg::*;
();

  logic [CMD_W-1:0]   i_cmd;
  logic               i_cmd_we;
  logic [RATIO_W-1:0] o_ratio_r;
  logic [RATIO_W-1:0] o_ratio_l;
  logic               o_busy;
  logic               o_wdt_trip;

  modport master (
    output i_cmd, i_cmd_we,
    input  o_ratio_r, o_ratio_l, o_busy, o_wdt_trip
  );

  modport slave (
    input  i_cmd, i_cmd_we,
    output o_ratio_r, o_ratio_l, o_busy, o_wdt_trip
  );

endinterface

// File: rtl/motor_ramp_ch.sv
// One motor channel: saturating slew of the current ratio toward its target.
module motor_ramp_ch
  import motor_ramp_pkg::*;
#(
  parameter int unsigned STEP_SIZE = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_x,
  input  logic               tick,
  input  logic [RATIO_W-1:0] target,
  input  logic               brake_now,
  output logic [RATIO_W-1:0] ratio
);

  localparam int unsigned EXT_W = RATIO_W + 1;
  localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(STEP_SIZE);

  logic        [EXT_W-1:0]   up_c;
  logic signed [EXT_W-1:0]   dn_c;
  logic        [EXT_W-1:0]   tgt_ext_c;
  logic        [RATIO_W-1:0] nxt_c;

  // 9-bit arithmetic keeps the sum below 512 and the difference above -256
  always_comb begin
    tgt_ext_c = {1'b0, target};
    up_c      = {1'b0, ratio} + STEP_EXT;
    dn_c      = $signed({1'b0, ratio}) - $signed(STEP_EXT);
    nxt_c     = ratio;
    if (ratio < target) begin
      nxt_c = (up_c > tgt_ext_c) ? target : up_c[RATIO_W-1:0];
    end else if (ratio > target) begin
      nxt_c = (dn_c < $signed(tgt_ext_c)) ? target : dn_c[RATIO_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      ratio <= '0;
    end else if (brake_now) begin
      ratio <= '0;
    end else if (tick) begin
      ratio <= nxt_c;
    end
  end

endmodule

// File: rtl/motor_ramp.sv
// Slew-rate limiter and command watchdog feeding the two motor PWM ratios.
// Optional emergency brake: define MOTOR_RAMP_BRAKE_EN.
module motor_ramp
  import motor_ramp_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 100000,
  parameter int unsigned STEP_SIZE   = 4,
  parameter int unsigned WDT_CYCLES  = 50000000
) (
  input  logic        i_clk,
  input  logic        i_rst_x,
  motor_ramp_if.slave bus
);

  localparam int unsigned TICK_W = 24;
  localparam int unsigned WDT_W  = 32;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_CYCLES - 1);

  logic [TICK_W-1:0]  tick_cnt;
  logic [WDT_W-1:0]   wdt_cnt;
  logic [RATIO_W-1:0] tgt_r, tgt_l;
  logic [RATIO_W-1:0] ratio_r, ratio_l;
  logic [RATIO_W-1:0] cmd_r_c, cmd_l_c;
  logic               wdt_trip;
  logic               busy;
  logic               tick_c, expire_c, mismatch_c;
  logic               brake_r_c, brake_l_c;
  state_e             state, state_nxt;

  assign cmd_r_c    = bus.i_cmd[RIGHT_LSB +: RATIO_W];
  assign cmd_l_c    = bus.i_cmd[LEFT_LSB  +: RATIO_W];
  assign tick_c     = (tick_cnt == TICK_LAST);
  assign mismatch_c = (ratio_r != tgt_r) || (ratio_l != tgt_l);
  // A write in the expiry cycle wins; once tripped the held count cannot re-trip
  assign expire_c   = (wdt_cnt == WDT_LAST) && !bus.i_cmd_we && !wdt_trip;

`ifdef MOTOR_RAMP_BRAKE_EN
  assign brake_r_c = (bus.i_cmd_we && (cmd_r_c == '0)) || expire_c;
  assign brake_l_c = (bus.i_cmd_we && (cmd_l_c == '0)) || expire_c;
`else
  assign brake_r_c = 1'b0;
  assign brake_l_c = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      wdt_cnt <= '0;
    end else if (bus.i_cmd_we) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_LAST) begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      tgt_r    <= '0;
      tgt_l    <= '0;
      wdt_trip <= 1'b0;
    end else if (bus.i_cmd_we) begin
      tgt_r    <= cmd_r_c;
      tgt_l    <= cmd_l_c;
      wdt_trip <= 1'b0;
    end else if (expire_c) begin
      tgt_r    <= '0;
      tgt_l    <= '0;
      wdt_trip <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      busy  <= 1'b0;
      state <= ST_IDLE;
    end else begin
      busy  <= mismatch_c;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (expire_c)        state_nxt = ST_TRIP;
        else if (mismatch_c) state_nxt = ST_RAMP;
      end
      ST_RAMP: begin
        if (expire_c)         state_nxt = ST_TRIP;
        else if (!mismatch_c) state_nxt = ST_IDLE;
      end
      ST_TRIP: begin
        if (bus.i_cmd_we) begin
          state_nxt = ((cmd_r_c != ratio_r) || (cmd_l_c != ratio_l)) ? ST_RAMP : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  motor_ramp_ch #(.STEP_SIZE(STEP_SIZE)) u_ch_r (
    .i_clk     (i_clk),
    .i_rst_x   (i_rst_x),
    .tick      (tick_c),
    .target    (tgt_r),
    .brake_now (brake_r_c),
    .ratio     (ratio_r)
  );

  motor_ramp_ch #(.STEP_SIZE(STEP_SIZE)) u_ch_l (
    .i_clk     (i_clk),
    .i_rst_x   (i_rst_x),
    .tick      (tick_c),
    .target    (tgt_l),
    .brake_now (brake_l_c),
    .ratio     (ratio_l)
  );

  assign bus.o_ratio_r  = ratio_r;
  assign bus.o_ratio_l  = ratio_l;
  assign bus.o_busy     = busy;
  assign bus.o_wdt_trip = wdt_trip;

endmodule
